// File: rtl/line_buff_pkg.sv
// line_buff_pkg: shared types and default geometry for the line-buffer ring.
// Optional underrun counter is enabled by defining LBC_UNDERRUN_CNT_EN.
package line_buff_pkg;

  typedef enum logic [1:0] {
    EMPTY      = 2'd0,
    FILLING    = 2'd1,
    FULL       = 2'd2,
    DISPLAYING = 2'd3
  } buff_state_t;

  localparam int LBC_WIDTH_PX    = 640;
  localparam int LBC_HEIGHT_LNS  = 480;
  localparam int LBC_H_ACT_START = 144;
  localparam int LBC_V_ACT_START = 35;
  localparam int LBC_TILE_WIDTH  = 4;
  localparam int LBC_H_ACT_END   = LBC_H_ACT_START + LBC_WIDTH_PX;
  localparam int LBC_V_ACT_END   = LBC_V_ACT_START + LBC_HEIGHT_LNS;
  localparam int LBC_TILE_ROWS   = LBC_HEIGHT_LNS / LBC_TILE_WIDTH;

  function automatic int act_end(input int start, input int len);
    return start + len;
  endfunction

  function automatic int tile_rows(input int lines, input int tw);
    return lines / tw;
  endfunction

endpackage

// File: rtl/line_buff_slot.sv
// line_buff_slot: life cycle of one ring buffer.
// EMPTY -> FILLING -> FULL -> DISPLAYING -> EMPTY, cleared at frame start.
module line_buff_slot
  import line_buff_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        fill_go_i,
  input  logic        done_i,
  input  logic        disp_start_i,
  input  logic        release_i,
  output buff_state_t state_o,
  output logic        req_o
);

  buff_state_t state_q;
  buff_state_t state_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY:      if (fill_go_i) state_d = FILLING;
        FILLING:    if (done_i) state_d = FULL;
        // a late fill still gets recycled when its row ends
        FULL: begin
          if (disp_start_i)   state_d = DISPLAYING;
          else if (release_i) state_d = EMPTY;
        end
        DISPLAYING: if (release_i) state_d = EMPTY;
        default:    state_d = EMPTY;
      endcase
    end
  end

  assign state_o = state_q;
  assign req_o   = (state_q == FILLING);

endmodule

// File: rtl/line_buff_ring_ctrl.sv
// line_buff_ring_ctrl: fill/display pointer ring over N_BUFF tile-row buffers.
// Define LBC_UNDERRUN_CNT_EN to enable the saturating underrun counter.
module line_buff_ring_ctrl
  import line_buff_pkg::*;
#(
  parameter int WIDTH_PX           = LBC_WIDTH_PX,
  parameter int HEIGHT_LNS         = LBC_HEIGHT_LNS,
  parameter int H_B_PORCH_MAX_PX   = LBC_H_ACT_START,
  parameter int V_B_PORCH_MAX_LNS  = LBC_V_ACT_START,
  parameter int TILE_WIDTH         = LBC_TILE_WIDTH,
  parameter int N_BUFF             = 2,
  parameter int PXL_CTR_WIDTH      = 10,
  parameter int LN_CTR_WIDTH       = 10,
  parameter int TILE_PER_LINE      = WIDTH_PX / TILE_WIDTH,
  parameter int TILE_CTR_WIDTH     = $clog2(TILE_PER_LINE),
  parameter int UNDERRUN_CTR_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [PXL_CTR_WIDTH-1:0]      pxl_cntr_i,
  input  logic [LN_CTR_WIDTH-1:0]       ln_cntr_i,
  input  logic [N_BUFF-1:0]             buff_fill_done_i,
  output logic [N_BUFF-1:0]             buff_fill_req_o,
  output logic [N_BUFF-1:0]             buff_sel_o,
  output logic [TILE_CTR_WIDTH-1:0]     disp_pxl_id_o,
  output logic                          disp_valid_o,
  output logic                          underrun_o,
  output logic [UNDERRUN_CTR_WIDTH-1:0] underrun_cnt_o
);

  localparam int PTR_W = $clog2(N_BUFF);
  localparam int ROWS  = tile_rows(HEIGHT_LNS, TILE_WIDTH);
  localparam int ROW_W = $clog2(ROWS + 1);

  localparam logic [PXL_CTR_WIDTH-1:0] H_START =
    PXL_CTR_WIDTH'(H_B_PORCH_MAX_PX);
  localparam logic [PXL_CTR_WIDTH-1:0] H_END =
    PXL_CTR_WIDTH'(act_end(H_B_PORCH_MAX_PX, WIDTH_PX));
  localparam logic [PXL_CTR_WIDTH-1:0] H_LAST =
    PXL_CTR_WIDTH'(act_end(H_B_PORCH_MAX_PX, WIDTH_PX) - 1);
  localparam logic [LN_CTR_WIDTH-1:0] V_START =
    LN_CTR_WIDTH'(V_B_PORCH_MAX_LNS);
  localparam logic [LN_CTR_WIDTH-1:0] V_END =
    LN_CTR_WIDTH'(act_end(V_B_PORCH_MAX_LNS, HEIGHT_LNS));
  localparam logic [PXL_CTR_WIDTH-1:0] TW_H = PXL_CTR_WIDTH'(TILE_WIDTH);
  localparam logic [LN_CTR_WIDTH-1:0]  TW_V = LN_CTR_WIDTH'(TILE_WIDTH);
  localparam logic [LN_CTR_WIDTH-1:0]  TW_V_LAST =
    LN_CTR_WIDTH'(TILE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROWS_L = ROW_W'(ROWS);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_BUFF - 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  buff_state_t st [N_BUFF];
  logic [N_BUFF-1:0] req;
  logic [N_BUFF-1:0] filling;
  logic [N_BUFF-1:0] ready;

  logic [PTR_W-1:0]          fill_ptr_q, fill_ptr_d;
  logic [PTR_W-1:0]          disp_ptr_q, disp_ptr_d;
  logic [ROW_W-1:0]          fill_row_q, fill_row_d;
  logic                      line_ok_q, line_ok_d;
  logic [N_BUFF-1:0]         sel_q, sel_d;
  logic [TILE_CTR_WIDTH-1:0] id_q, id_d;
  logic                      valid_q, valid_d;
  logic                      urun_q, urun_d;

  logic                      frame_start;
  logic                      act;
  logic                      first_px;
  logic                      last_px;
  logic                      row_first;
  logic                      row_last;
  logic                      row_start;
  logic                      rel;
  logic                      done_acc;
  logic                      fill_ok;
  logic                      disp_ready;
  logic [PXL_CTR_WIDTH-1:0]  hoff;
  logic [LN_CTR_WIDTH-1:0]   voff;
  logic [LN_CTR_WIDTH-1:0]   vsub;

  assign frame_start = (ln_cntr_i == '0) && (pxl_cntr_i == '0);
  assign act = (pxl_cntr_i >= H_START) && (pxl_cntr_i < H_END) &&
               (ln_cntr_i >= V_START) && (ln_cntr_i < V_END);
  assign hoff       = pxl_cntr_i - H_START;
  assign voff       = ln_cntr_i - V_START;
  assign vsub       = voff % TW_V;
  assign first_px   = act && (pxl_cntr_i == H_START);
  assign last_px    = act && (pxl_cntr_i == H_LAST);
  assign row_first  = (vsub == '0);
  assign row_last   = (vsub == TW_V_LAST);
  assign row_start  = first_px && row_first;
  assign rel        = last_px && row_last;
  assign fill_ok    = (fill_row_q < ROWS_L);
  assign disp_ready = ready[disp_ptr_q];
  assign done_acc   = |(buff_fill_done_i & filling) && !frame_start;

  for (genvar g = 0; g < N_BUFF; g++) begin : g_slot
    logic here_fill;
    logic here_disp;
    assign here_fill = (fill_ptr_q == PTR_W'(g));
    assign here_disp = (disp_ptr_q == PTR_W'(g));

    line_buff_slot u_slot (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .clr_i        (frame_start),
      .fill_go_i    (here_fill && fill_ok),
      .done_i       (buff_fill_done_i[g]),
      .disp_start_i (here_disp && row_start),
      .release_i    (here_disp && rel),
      .state_o      (st[g]),
      .req_o        (req[g])
    );

    assign filling[g] = (st[g] == FILLING);
    assign ready[g]   = (st[g] == FULL) || (st[g] == DISPLAYING);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fill_ptr_q <= '0;
      disp_ptr_q <= '0;
      fill_row_q <= '0;
      line_ok_q  <= 1'b0;
      sel_q      <= '0;
      id_q       <= '0;
      valid_q    <= 1'b0;
      urun_q     <= 1'b0;
    end else begin
      fill_ptr_q <= fill_ptr_d;
      disp_ptr_q <= disp_ptr_d;
      fill_row_q <= fill_row_d;
      line_ok_q  <= line_ok_d;
      sel_q      <= sel_d;
      id_q       <= id_d;
      valid_q    <= valid_d;
      urun_q     <= urun_d;
    end
  end

  always_comb begin
    fill_ptr_d = fill_ptr_q;
    disp_ptr_d = disp_ptr_q;
    fill_row_d = fill_row_q;
    line_ok_d  = line_ok_q;
    sel_d      = sel_q;
    if (frame_start) begin
      fill_ptr_d = '0;
      disp_ptr_d = '0;
      fill_row_d = '0;
      line_ok_d  = 1'b0;
      sel_d      = '0;
      sel_d[0]   = 1'b1;
    end else begin
      if (done_acc) begin
        fill_ptr_d = ptr_inc(fill_ptr_q);
        fill_row_d = fill_row_q + 1'b1;
      end
      if (first_px) line_ok_d = disp_ready;
      if (rel) begin
        disp_ptr_d        = ptr_inc(disp_ptr_q);
        sel_d             = '0;
        sel_d[disp_ptr_d] = 1'b1;
      end
    end
  end

  // the verdict taken at the first pixel holds for the whole line
  always_comb begin
    id_d    = '0;
    valid_d = 1'b0;
    urun_d  = first_px && !disp_ready;
    if (act) begin
      id_d    = TILE_CTR_WIDTH'(hoff / TW_H);
      valid_d = first_px ? disp_ready : line_ok_q;
    end
  end

`ifdef LBC_UNDERRUN_CNT_EN
  logic [UNDERRUN_CTR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (urun_d && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  assign underrun_cnt_o = cnt_q;
`else
  assign underrun_cnt_o = '0;
`endif

  assign buff_fill_req_o = req;
  assign buff_sel_o      = sel_q;
  assign disp_pxl_id_o   = id_q;
  assign disp_valid_o    = valid_q;
  assign underrun_o      = urun_q;

endmodule

// File: tb/tb_line_buff_ring_ctrl.sv
// tb_line_buff_ring_ctrl: directed checks of the ring controller,
// two-buffer default plus a four-buffer instance.
module tb_line_buff_ring_ctrl;

`ifdef LBC_UNDERRUN_CNT_EN
  localparam logic [15:0] EXP_CNT1 = 16'd1;
`else
  localparam logic [15:0] EXP_CNT1 = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pxl, ln, pxl4, ln4;
  logic [1:0]  done;
  logic [3:0]  done4;
  logic [1:0]  req, sel;
  logic [3:0]  req4, sel4;
  logic [7:0]  id, id4;
  logic        valid, valid4, urun, urun4;
  logic [15:0] cnt, cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  line_buff_ring_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .pxl_cntr_i       (pxl),
    .ln_cntr_i        (ln),
    .buff_fill_done_i (done),
    .buff_fill_req_o  (req),
    .buff_sel_o       (sel),
    .disp_pxl_id_o    (id),
    .disp_valid_o     (valid),
    .underrun_o       (urun),
    .underrun_cnt_o   (cnt)
  );

  line_buff_ring_ctrl #(.N_BUFF(4)) dut4 (
    .clk_i            (clk),
    .rst_i            (rst),
    .pxl_cntr_i       (pxl4),
    .ln_cntr_i        (ln4),
    .buff_fill_done_i (done4),
    .buff_fill_req_o  (req4),
    .buff_sel_o       (sel4),
    .disp_pxl_id_o    (id4),
    .disp_valid_o     (valid4),
    .underrun_o       (urun4),
    .underrun_cnt_o   (cnt4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; pxl = 10'd100; ln = 10'd300; done = '0;
    pxl4 = 10'd100; ln4 = 10'd300; done4 = '0;
    step(); step();
    check("rst_req", 32'(req), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_id", 32'(id), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_urun", 32'(urun), 32'h0);
    check("rst_cnt", 32'(cnt), 32'h0);
    rst = 1'b0;
    step();
    check("req_after_rst", 32'(req), 32'h1);

    // frame start drops the request, it re-arms one cycle later
    ln = 10'd0; pxl = 10'd0;
    step();
    check("fs_req", 32'(req), 32'h0);
    check("fs_sel", 32'(sel), 32'h1);
    pxl = 10'd1;
    step();
    check("fs_rearm", 32'(req), 32'h1);
    repeat (63) step();
    done = 2'b01;
    step();
    done = '0;
    check("done0_drop", 32'(req), 32'h0);
    step();
    check("req1_rise", 32'(req), 32'h2);
    done = 2'b10;
    step();
    done = '0;
    check("done1_drop", 32'(req), 32'h0);
    step();
    check("ring_full", 32'(req), 32'h0);

    ln = 10'd35; pxl = 10'd144;
    step();
    check("id_144", 32'(id), 32'd0);
    check("valid_144", 32'(valid), 32'h1);
    check("sel_144", 32'(sel), 32'h1);
    check("urun_ok", 32'(urun), 32'h0);
    pxl = 10'd148;
    step();
    check("id_148", 32'(id), 32'd1);
    pxl = 10'd783;
    step();
    check("id_783", 32'(id), 32'd159);
    check("valid_783", 32'(valid), 32'h1);
    pxl = 10'd784;
    step();
    check("id_784", 32'(id), 32'd0);
    check("valid_784", 32'(valid), 32'h0);
    ln = 10'd36; pxl = 10'd144;
    step();
    check("valid_ln36", 32'(valid), 32'h1);

    ln = 10'd38; pxl = 10'd783;
    step();
    check("rot_sel", 32'(sel), 32'h2);
    check("rot_req_t1", 32'(req), 32'h0);
    pxl = 10'd784;
    step();
    check("rot_req_t2", 32'(req), 32'h1);
    ln = 10'd39; pxl = 10'd144;
    step();
    check("row1_valid", 32'(valid), 32'h1);
    check("row1_urun", 32'(urun), 32'h0);

    // second frame: buffer 1 never completes
    ln = 10'd0; pxl = 10'd0;
    step();
    check("fs2_sel", 32'(sel), 32'h1);
    pxl = 10'd1;
    step();
    done = 2'b01;
    step();
    done = '0;
    step();
    check("f2_req1", 32'(req), 32'h2);
    ln = 10'd35; pxl = 10'd144;
    step();
    check("f2_valid", 32'(valid), 32'h1);
    ln = 10'd38; pxl = 10'd783;
    step();
    check("f2_rot_sel", 32'(sel), 32'h2);
    pxl = 10'd784;
    step();
    check("f2_req_hold", 32'(req), 32'h2);
    ln = 10'd39; pxl = 10'd144;
    step();
    check("urun_pulse", 32'(urun), 32'h1);
    check("urun_valid", 32'(valid), 32'h0);
    check("urun_cnt", 32'(cnt), 32'(EXP_CNT1));
    pxl = 10'd145;
    step();
    check("urun_one_cyc", 32'(urun), 32'h0);
    check("urun_line_lo", 32'(valid), 32'h0);
    check("urun_cnt_hold", 32'(cnt), 32'(EXP_CNT1));

    // done coincident with frame start, then a late done: both ignored
    ln = 10'd0; pxl = 10'd0; done = 2'b10;
    step();
    check("fs_done_req", 32'(req), 32'h0);
    pxl = 10'd1;
    step();
    done = '0;
    check("late_done_req", 32'(req), 32'h1);
    step();
    check("late_done_hold", 32'(req), 32'h1);

    // four-buffer ring: sequential requests and a stray done
    ln4 = 10'd0; pxl4 = 10'd0;
    step();
    pxl4 = 10'd1;
    step();
    for (int i = 0; i < 4; i++) begin
      check("n4_req", 32'(req4), 32'(1 << i));
      if (i == 3) begin
        done4 = 4'b0100;
        step();
        done4 = '0;
        check("n4_stray", 32'(req4), 32'h8);
      end
      done4 = 4'(1 << i);
      step();
      done4 = '0;
      check("n4_drop", 32'(req4), 32'h0);
      step();
    end
    check("n4_idle", 32'(req4), 32'h0);
    ln4 = 10'd35; pxl4 = 10'd144;
    step();
    check("n4_valid", 32'(valid4), 32'h1);
    check("n4_sel", 32'(sel4), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/line_buff_ring_ctrl.md
# line_buff_ring_ctrl

Parametrised line-buffer controller managing a ring of `N_BUFF` tile-row buffers between the memory fill engine and the VGA pixel pipeline. It issues fill requests ahead of the raster, selects the buffer being displayed, and produces the tile index for the current pixel. It also detects display underruns. It sits between the pixel/line counters and the line buffer array, and supersedes the fixed two-buffer controller.

## Interface
- `WIDTH_PX`, 640, active pixels per line
- `HEIGHT_LNS`, 480, active lines per frame
- `H_B_PORCH_MAX_PX`, 144, first active pixel count (sync + back porch)
- `V_B_PORCH_MAX_LNS`, 35, first active line count
- `TILE_WIDTH`, 4, tile edge in pixels/lines; must divide `WIDTH_PX` and `HEIGHT_LNS`
- `N_BUFF`, 2, number of buffers in the ring; legal range 2..8
- `PXL_CTR_WIDTH`, 10, pixel counter width
- `LN_CTR_WIDTH`, 10, line counter width
- `TILE_PER_LINE`, `WIDTH_PX/TILE_WIDTH`, tiles per active line
- `TILE_CTR_WIDTH`, `$clog2(TILE_PER_LINE)`, tile index width
- `UNDERRUN_CTR_WIDTH`, 16, underrun counter width
- `clk_i` in 1: pixel clock
- `rst_i` in 1: asynchronous, active-high reset
- `pxl_cntr_i` in `PXL_CTR_WIDTH`: horizontal pixel count
- `ln_cntr_i` in `LN_CTR_WIDTH`: vertical line count
- `buff_fill_done_i` in `N_BUFF`: one-cycle pulse per buffer, fill complete
- `buff_fill_req_o` out `N_BUFF`: level request per buffer, at most one bit high
- `buff_sel_o` out `N_BUFF`: one-hot select of the display buffer
- `disp_pxl_id_o` out `TILE_CTR_WIDTH`: tile index within the current line
- `disp_valid_o` out 1: active pixel with valid buffer data
- `underrun_o` out 1: one-cycle pulse, display needed an unfilled buffer
- `underrun_cnt_o` out `UNDERRUN_CTR_WIDTH`: saturating underrun count

## Operation
- Active region: `H_B_PORCH_MAX_PX <= pxl < H_B_PORCH_MAX_PX+WIDTH_PX`, and `V_B_PORCH_MAX_LNS <= ln < V_B_PORCH_MAX_LNS+HEIGHT_LNS`.
- Tile row `r = (ln - V_B_PORCH_MAX_LNS)/TILE_WIDTH`. Row `r` is held in buffer `r mod N_BUFF`.
- Per-buffer FSM states: EMPTY, FILLING, FULL, DISPLAYING.
  - EMPTY→FILLING when `fill_ptr` points at the buffer and `fill_row < HEIGHT_LNS/TILE_WIDTH`.
  - FILLING→FULL on its done pulse.
  - FULL→DISPLAYING on the first active pixel of the buffer's tile row.
  - DISPLAYING→EMPTY on release.
- Only one buffer is FILLING at a time. Fills are issued in ring order. `fill_ptr` and `fill_row` advance when the done pulse is accepted.
- A done pulse on a buffer not in FILLING is ignored.
- Release happens at the last active pixel of the last line of a tile row (`(ln-V_B_PORCH_MAX_LNS) mod TILE_WIDTH == TILE_WIDTH-1`, `pxl == H_B_PORCH_MAX_PX+WIDTH_PX-1`). `disp_ptr` then advances modulo `N_BUFF`.
- Frame start (`ln==0 && pxl==0`): all buffers go to EMPTY, pointers and `fill_row` go to 0, and any pending request is dropped. A done pulse arriving late after this is ignored.
- `disp_pxl_id_o = (pxl - H_B_PORCH_MAX_PX)/TILE_WIDTH` in the active region, else 0.
- Underrun: at the first active pixel of any active line, if the display buffer is not FULL or DISPLAYING:
  - pulse `underrun_o`;
  - hold `disp_valid_o` low for that line.
  - The ring does not advance until the row completes.

## Timing
- Reset: all outputs 0, all buffers EMPTY, all pointers 0.
- `disp_pxl_id_o`, `disp_valid_o`, `buff_sel_o` and `underrun_o` are registered: 1-cycle latency from the counter inputs.
- Request latency:
  - A buffer becoming eligible at cycle t asserts its request at t+1.
  - A done pulse at cycle d drops the request at d+1. The buffer is FULL at d+1.
  - The next buffer's request rises at d+2.
- A done pulse coincident with frame start is ignored, because frame start wins.
- Release and the next request: the buffer is EMPTY at t+1 and its request rises at t+2.
- `buff_sel_o` changes only on release or frame start.

## Configuration
- `LBC_UNDERRUN_CNT_EN` defined: `underrun_cnt_o` increments on each `underrun_o` pulse and saturates at all-ones. It is cleared only by `rst_i`.
- `LBC_UNDERRUN_CNT_EN` undefined: `underrun_cnt_o` is tied to 0. `underrun_o` is unaffected.

## Structure
- Package `line_buff_pkg` holds:
  - `buff_state_t` enum (EMPTY, FILLING, FULL, DISPLAYING);
  - derived constants for active-region bounds and tile rows per frame.
- Sub-module `line_buff_slot`: the per-buffer FSM. It is instantiated `N_BUFF` times in a generate loop. Top-level pointer logic lives in `line_buff_ring_ctrl`.

## Test plan
- Hold `rst_i` high mid-frame: all outputs 0. Release: `buff_fill_req_o=2'b01` one cycle after the first edge.
- Prefill: pulse `buff_fill_done_i[0]` 64 cycles after the request. The request drops at d+1, and `buff_fill_req_o=2'b10` at d+2.
- Display id with `TILE_WIDTH=4`, one cycle after the inputs:
  - ln=35, pxl=144 → `disp_pxl_id_o=0`, valid=1, `buff_sel_o=01`;
  - pxl=148 → 1;
  - pxl=783 → 159;
  - pxl=784 → 0, valid=0.
- Rotation: after ln=38, pxl=783, `buff_sel_o=10`, and `buff_fill_req_o[0]` rises 2 cycles later.
- Underrun: withhold `buff_fill_done_i[1]`. At ln=39, pxl=144 → `underrun_o` one-cycle pulse and valid=0 for the line. `underrun_cnt_o=1` with `LBC_UNDERRUN_CNT_EN`, 0 without.
- `N_BUFF=4`: 4 sequential requests complete before ln=35. A stray `buff_fill_done_i[2]` while buffer 2 is FULL is ignored.
